// File: rtl/minkowski_net_pipe_mul_acc.sv
// Pipelined multiplier with per-operand signedness and an optional running
// accumulator in the final stage; ready/valid handshake on input and output.
module minkowski_net_pipe_mul_acc #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 2,
   parameter int DIN0_WIDTH = 11,
   parameter int DIN1_WIDTH = 11,
   parameter int DOUT_WIDTH = 22
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  din0_signed,
   input  logic                  din1_signed,
   input  logic                  acc_en,
   input  logic                  acc_clr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout
);

   localparam int PW    = DIN0_WIDTH + DIN1_WIDTH + 2;
   localparam int MW    = (DOUT_WIDTH > PW) ? DOUT_WIDTH : PW;
   // With a single stage there are no delay stages; keep one dummy slot so the array stays legal.
   localparam int DEPTH = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

   typedef struct packed {
      logic                  vld;
      logic [DIN0_WIDTH-1:0] a;
      logic [DIN1_WIDTH-1:0] b;
      logic                  a_s;
      logic                  b_s;
      logic                  en;
      logic                  clr;
   } beat_t;

   beat_t                  pipe_q [DEPTH];
   beat_t                  pipe_d [DEPTH];
   beat_t                  in_beat_s;
   beat_t                  fin_beat_s;
   logic                   ce_s;
   logic signed [DIN0_WIDTH:0] ext0_s;
   logic signed [DIN1_WIDTH:0] ext1_s;
   logic [DOUT_WIDTH-1:0]  prod_s;
   logic                   out_valid_q;
   logic                   out_valid_d;
   logic [DOUT_WIDTH-1:0]  dout_q;
   logic [DOUT_WIDTH-1:0]  dout_d;
   logic [DOUT_WIDTH-1:0]  acc_q;
   logic [DOUT_WIDTH-1:0]  acc_d;

   assign ce_s      = !out_valid_q || out_ready;
   assign in_ready  = ce_s;
   assign out_valid = out_valid_q;
   assign dout      = dout_q;

   // Beat capture and shift through the delay stages ahead of the final stage
   always_comb begin
      in_beat_s = '{vld: in_valid, a: din0, b: din1, a_s: din0_signed,
                    b_s: din1_signed, en: acc_en, clr: acc_clr};
      pipe_d = pipe_q;
      if (ce_s) begin
         pipe_d[0] = in_beat_s;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
      end else begin
         pipe_d = pipe_q;
      end
      fin_beat_s = (NUM_STAGE == 1) ? in_beat_s : pipe_q[DEPTH-1];
   end

   // Operand extension and product, wrapped to the result width
   always_comb begin
      ext0_s = $signed({fin_beat_s.a_s & fin_beat_s.a[DIN0_WIDTH-1], fin_beat_s.a});
      ext1_s = $signed({fin_beat_s.b_s & fin_beat_s.b[DIN1_WIDTH-1], fin_beat_s.b});
      prod_s = DOUT_WIDTH'(MW'(ext0_s) * MW'(ext1_s));
   end

   // Final stage: result and accumulator change only when a valid beat enters
   always_comb begin
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      acc_d       = acc_q;
      if (ce_s) begin
         out_valid_d = fin_beat_s.vld;
         if (fin_beat_s.vld) begin
            case ({fin_beat_s.en, fin_beat_s.clr})
               2'b10: begin
                  dout_d = acc_q + prod_s;
                  acc_d  = acc_q + prod_s;
               end
               2'b11: begin
                  dout_d = prod_s;
                  acc_d  = prod_s;
               end
               2'b01: begin
                  dout_d = prod_s;
                  acc_d  = '0;
               end
               default: begin
                  dout_d = prod_s;
                  acc_d  = acc_q;
               end
            endcase
         end else begin
            dout_d = dout_q;
            acc_d  = acc_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         acc_q       <= '0;
      end else begin
         pipe_q      <= pipe_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         acc_q       <= acc_d;
      end
   end

endmodule

// File: tb/tb_minkowski_net_pipe_mul_acc.sv
// Bench: four instances (NUM_STAGE 1..4) checked against an arithmetic
// reference model with per-instance expected-result queues.
module tb_minkowski_net_pipe_mul_acc;

   logic        clk;
   logic        ap_rst;
   logic [3:0]  in_valid_r;
   logic [3:0]  in_ready_w;
   logic [3:0]  d0s_r;
   logic [3:0]  d1s_r;
   logic [3:0]  en_r;
   logic [3:0]  clr_r;
   logic [3:0]  out_valid_w;
   logic [3:0]  out_ready_r;
   logic [10:0] din0_r [4];
   logic [10:0] din1_r [4];
   logic [21:0] dout_w [4];

   int          checks;
   int          errors;
   logic [21:0] exp_q [4][$];
   logic [21:0] acc_m [4];
   logic [21:0] held;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      minkowski_net_pipe_mul_acc #(.ID(g), .NUM_STAGE(g + 1)) u_dut (
         .ap_clk      (clk),
         .ap_rst      (ap_rst),
         .in_valid    (in_valid_r[g]),
         .in_ready    (in_ready_w[g]),
         .din0        (din0_r[g]),
         .din1        (din1_r[g]),
         .din0_signed (d0s_r[g]),
         .din1_signed (d1s_r[g]),
         .acc_en      (en_r[g]),
         .acc_clr     (clr_r[g]),
         .out_valid   (out_valid_w[g]),
         .out_ready   (out_ready_r[g]),
         .dout        (dout_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [21:0] ref_prod(logic [10:0] a, logic [10:0] b, logic as, logic bs);
      longint x;
      longint y;
      longint p;
      x = longint'(a);
      y = longint'(b);
      if (as && a[10]) x = x - 2048;
      if (bs && b[10]) y = y - 2048;
      p = x * y;
      return p[21:0];
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: score handshakes mid-cycle, then advance to the next negedge.
   task automatic cycle();
      logic [21:0] p;
      logic [21:0] r;
      #1;
      if (ap_rst) begin
         for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            acc_m[k] = 22'd0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid_w[k] && out_ready_r[k]) begin
               checks++;
               assert (exp_q[k].size() > 0) else begin
                  errors++;
                  $error("FAIL out_unexpected dut%0d observed=%0h expected=none", k, dout_w[k]);
               end
               if (exp_q[k].size() > 0) chk($sformatf("dout_dut%0d", k), 64'(dout_w[k]), 64'(exp_q[k].pop_front()));
            end
            if (in_valid_r[k] && in_ready_w[k]) begin
               p = ref_prod(din0_r[k], din1_r[k], d0s_r[k], d1s_r[k]);
               if (!en_r[k]) begin
                  r = p;
                  if (clr_r[k]) acc_m[k] = 22'd0;
               end else if (clr_r[k]) begin
                  r = p;
                  acc_m[k] = p;
               end else begin
                  r = acc_m[k] + p;
                  acc_m[k] = r;
               end
               exp_q[k].push_back(r);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_all();
      in_valid_r  = 4'b0000;
      out_ready_r = 4'b1111;
      d0s_r = 4'b0000; d1s_r = 4'b0000; en_r = 4'b0000; clr_r = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         din0_r[k] = 11'd0;
         din1_r[k] = 11'd0;
      end
   endtask

   task automatic drive1(logic [10:0] a, logic [10:0] b, logic as, logic bs, logic e, logic c);
      in_valid_r[1] = 1'b1;
      din0_r[1] = a; din1_r[1] = b;
      d0s_r[1] = as; d1s_r[1] = bs; en_r[1] = e; clr_r[1] = c;
   endtask

   task automatic send_expect(string tag, logic [10:0] a, logic [10:0] b, logic as, logic bs,
                              logic e, logic c, logic [21:0] expv);
      drive1(a, b, as, bs, e, c);
      cycle();
      in_valid_r[1] = 1'b0;
      for (int n = 0; n < 8 && !out_valid_w[1]; n++) cycle();
      chk({tag, "_vld"}, 64'(out_valid_w[1]), 64'd1);
      chk(tag, 64'(dout_w[1]), 64'(expv));
      cycle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int k = 0; k < 4; k++) acc_m[k] = 22'd0;
      idle_all();
      ap_rst = 1'b1;
      cycle(); cycle(); cycle();
      ap_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_out_valid%0d", k), 64'(out_valid_w[k]), 64'd0);
         chk($sformatf("rst_in_ready%0d", k), 64'(in_ready_w[k]), 64'd1);
         chk($sformatf("rst_dout%0d", k), 64'(dout_w[k]), 64'd0);
      end

      // Latency: accepted in cycle T, visible in T+2 for NUM_STAGE=2
      drive1(11'd2047, 11'd2047, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      in_valid_r[1] = 1'b0;
      chk("lat_t1_vld", 64'(out_valid_w[1]), 64'd0);
      cycle();
      chk("lat_t2_vld", 64'(out_valid_w[1]), 64'd1);
      chk("lat_t2_dout", 64'(dout_w[1]), 64'd4190209);
      cycle();

      send_expect("signed_mix", 11'h7FF, 11'd3, 1'b1, 1'b0, 1'b0, 1'b0, 22'h3FFFFD);
      send_expect("unsigned_mix", 11'h7FF, 11'd3, 1'b0, 1'b0, 1'b0, 1'b0, 22'd6141);

      send_expect("acc_clr", 11'd2, 11'd3, 1'b0, 1'b0, 1'b1, 1'b1, 22'd6);
      send_expect("acc_add1", 11'd4, 11'd5, 1'b0, 1'b0, 1'b1, 1'b0, 22'd26);
      send_expect("acc_add2", 11'd1, 11'd1, 1'b0, 1'b0, 1'b1, 1'b0, 22'd27);
      send_expect("acc_noen", 11'd7, 11'd7, 1'b0, 1'b0, 1'b0, 1'b0, 22'd49);
      send_expect("acc_final", 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 22'd27);

      // Backpressure with the pipe full and accumulating beats stalled
      out_ready_r[1] = 1'b0;
      drive1(11'($urandom), 11'($urandom), 1'b1, 1'b0, 1'b1, 1'b1);
      cycle();
      drive1(11'($urandom), 11'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
      cycle();
      held = dout_w[1];
      for (int n = 0; n < 5; n++) begin
         chk("bp_in_ready", 64'(in_ready_w[1]), 64'd0);
         chk("bp_dout_stable", 64'(dout_w[1]), 64'(held));
         drive1(11'($urandom), 11'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
         cycle();
      end
      in_valid_r[1]  = 1'b0;
      out_ready_r[1] = 1'b1;
      for (int n = 0; n < 6; n++) cycle();
      chk("bp_drained", 64'(exp_q[1].size()), 64'd0);

      // Reset with two beats in flight
      drive1(11'd9, 11'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
      drive1(11'd8, 11'd8, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
      in_valid_r[1]  = 1'b0;
      out_ready_r[1] = 1'b0;
      ap_rst = 1'b1;
      cycle();
      ap_rst = 1'b0;
      out_ready_r[1] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         chk("mid_rst_quiet", 64'(out_valid_w[1]), 64'd0);
         cycle();
      end
      send_expect("post_rst_acc", 11'd5, 11'd6, 1'b0, 1'b0, 1'b1, 1'b0, 22'd30);

      // Random sweep across all four stage depths
      for (int n = 0; n < 800; n++) begin
         for (int k = 0; k < 4; k++) begin
            in_valid_r[k]  = ($urandom_range(0, 9) < 7);
            out_ready_r[k] = ($urandom_range(0, 9) < 7);
            din0_r[k] = 11'($urandom);
            din1_r[k] = 11'($urandom);
            d0s_r[k]  = 1'($urandom);
            d1s_r[k]  = 1'($urandom);
            en_r[k]   = 1'($urandom);
            clr_r[k]  = ($urandom_range(0, 9) < 2);
         end
         cycle();
      end
      in_valid_r  = 4'b0000;
      out_ready_r = 4'b1111;
      for (int n = 0; n < 10; n++) cycle();
      for (int k = 0; k < 4; k++) chk($sformatf("sweep_drained%0d", k), 64'(exp_q[k].size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/minkowski_net_pipe_mul_acc.md
MINKOWSKI_NET_PIPE_MUL_ACC -- requirements
Module: minkowski_net_pipe_mul_acc

Interface
REQ-001 The block SHALL have parameter ID, default 1, meaning instance tag; it has no functional effect.
REQ-002 The block SHALL have parameter NUM_STAGE, default 2, meaning register stages from input accept to output; legal range is 1..4.
REQ-003 The block SHALL have parameter DIN0_WIDTH, default 11, meaning width of operand 0.
REQ-004 The block SHALL have parameter DIN1_WIDTH, default 11, meaning width of operand 1.
REQ-005 The block SHALL have parameter DOUT_WIDTH, default 22, meaning result and accumulator width.
REQ-006 The block SHALL use one clock, ap_clk; reset ap_rst is synchronous and active-high.
REQ-007 The block SHALL have these ports:
- ap_clk  input  1  clock.
- ap_rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- din0  input  DIN0_WIDTH  operand 0.
- din1  input  DIN1_WIDTH  operand 1.
- din0_signed  input  1  operand 0 is two's complement when 1, unsigned when 0.
- din1_signed  input  1  operand 1 is two's complement when 1, unsigned when 0.
- acc_en  input  1  add the product to the accumulator.
- acc_clr  input  1  restart accumulation with this beat.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- dout  output  DOUT_WIDTH  result.

Function
REQ-008 A beat SHALL be accepted when in_valid and in_ready are both 1; a result SHALL transfer when out_valid and out_ready are both 1.
REQ-009 Global advance enable SHALL be ce = !out_valid || out_ready; in_ready SHALL equal ce.
REQ-010 When ce=1, every stage SHALL shift one position, and stage 1 SHALL load the input beat with its valid bit set to in_valid.
REQ-011 When ce=0, all stage registers and valid bits SHALL hold their values.
REQ-012 Each operand SHALL be extended by one bit: the sign bit when its signed flag is 1, zero when it is 0.
REQ-013 The extended operands SHALL be multiplied signed to give a full product of DIN0_WIDTH+DIN1_WIDTH+2 bits.
REQ-014 The product SHALL be sign-extended or truncated to DOUT_WIDTH.
REQ-015 Truncation SHALL keep the low bits and wrap; there is no saturation.
REQ-016 Without stalls, a beat accepted in cycle T SHALL give out_valid=1 in cycle T+NUM_STAGE.
REQ-017 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-018 acc_en, acc_clr and the signed flags SHALL travel through the pipeline with their beat.
REQ-019 The final stage SHALL compute its result when a valid beat enters it:
- acc_en=0: result = product; accumulator unchanged.
- acc_en=1, acc_clr=0: result = acc + product (mod 2^DOUT_WIDTH); acc updated to that result.
- acc_en=1, acc_clr=1: result = product; acc updated to product.
- acc_en=0, acc_clr=1: result = product; acc cleared to 0.
REQ-020 The accumulator SHALL update only when a valid beat enters the final stage with ce=1.
REQ-021 A stalled result SHALL never be accumulated twice.
REQ-022 Bubbles (in_valid=0 beats) SHALL change neither the accumulator nor out_valid.
REQ-023 dout SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 With NUM_STAGE=1, the final stage SHALL be the only stage; the product and accumulation are registered together.
REQ-025 in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-026 While ap_rst=1 at a clock edge, all stage valid bits, out_valid, dout and the accumulator SHALL become 0.
REQ-027 in_ready SHALL read 1 in the cycle after reset.
REQ-028 Reset during operation SHALL discard all in-flight beats without emitting them.
REQ-029 Reset SHALL take priority over a simultaneous accept or transfer.

Verification
REQ-030 Unsigned case, NUM_STAGE=2, defaults: din0=2047, din1=2047, both signed flags 0, accepted at T -> dout=4190209, out_valid=1 at T+2.
REQ-031 Signed case: din0=11'h7FF (-1) signed, din1=3 unsigned -> dout=-3 (22'h3FFFFD); same operands with both flags 0 -> 6141.
REQ-032 Accumulate sequence: beats (2,3,en,clr), (4,5,en), (1,1,en), (7,7,no en) -> dout 6, 26, 27, 49; accumulator ends at 27.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, dout stable, no beat lost or duplicated; a stalled accumulating beat is added exactly once.
REQ-034 Reset mid-stream: assert ap_rst with 2 beats in flight -> nothing is emitted afterwards; the next beat with acc_en=1, acc_clr=0 gives acc = product.
REQ-035 Random sweep over NUM_STAGE 1..4, random valid/ready and random signed/acc modes -> every output matches the reference model, in order.
